stack_op_sequencer: RTL and testbench
=====================================

# stack_op_sequencer

Sequencer for the 128×8 stack-calculator memory. It accepts one debounced operation at a time over a valid/ready handshake, and drives the memory's write-enable, address and write data. It owns the stack pointer (SPR) and the display address register (DAR), performs 8-bit add/subtract, and presents the current display value to the 7-segment path. It sits between the button/switch front end and the existing `memory` instance, replacing the ad-hoc state logic in the top level.

## Interface
Parameters:
- `AW`, 7: memory address width; depth is 2^AW.
- `DW`, 8: data width.

Ports:
- `clk`  in  1  system clock; every register is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  operation request.
- `cmd_op`  in  3  0 PUSH, 1 POP, 2 ADD, 3 SUB, 4 TOP, 5 CLEAR, 6 DAR_DEC, 7 DAR_INC.
- `cmd_din`  in  DW  push operand (switches); sampled at accept.
- `cmd_ready`  out  1  high only in IDLE.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  AW  memory address.
- `mem_wdata`  out  DW  memory write data.
- `mem_rdata`  in  DW  read data; valid one cycle after `mem_addr` is driven.
- `spr`, `dar`  out  AW  stack pointer and display address.
- `empty`  out  1  high when `spr == 7'h7F`.
- `full`  out  1  high when `spr == 0`.
- `result`  out  DW  display value, held between operations.
- `result_valid`  out  1  one-cycle pulse when an operation completes.
- `err`  out  1  one-cycle pulse, coincident with `result_valid`, when an operation is rejected.

## Operation
- Stack layout: grows downward from 0x7F. `spr` points to the next free slot, so the top of stack is at `spr+1`. Capacity is 127 entries (0x7F..0x01).
- Accept: an operation is accepted when `cmd_valid && cmd_ready`. `cmd_op` and `cmd_din` are captured at that edge.
- FSM states: IDLE, RD_A, RD_B, CAP_B, WRITE, FETCH, CAP_F, DONE.
  - DONE asserts `result_valid` and then returns to IDLE.
- PUSH: WRITE stores `cmd_din` at `spr`, then `spr--`, `dar = new spr+1`, `result = cmd_din`.
- POP: `spr++` and `dar = new spr+1`, then FETCH/CAP_F loads `result = mem[dar]`. If the stack is now empty, `dar = 0x00` (7-bit wrap) and `result = 0x00` with no read.
- ADD/SUB:
  - RD_A reads A at `spr+1`; RD_B reads B at `spr+2`.
  - WRITE stores B+A or B−A (mod 256) at `spr+2`, then `spr++`, `dar = new spr+1`, `result` = value written.
- TOP: `dar = spr+1`, then FETCH/CAP_F.
- DAR_INC / DAR_DEC: `dar ± 1` (mod 128, no stack check), then FETCH/CAP_F.
- CLEAR: `spr = 0x7F`, `dar = 0x00`, `result = 0x00`. Memory contents are untouched.
- Rejections (go straight to DONE with `err = 1`; `spr`, `dar`, `result` and memory unchanged):
  - PUSH when `full`.
  - POP when `empty`.
  - ADD/SUB with fewer than 2 entries (`spr > 0x7D`).
- Memory outputs: `mem_we` is high only in WRITE. `mem_addr` holds `dar` whenever the FSM is not reading or writing. `mem_wdata` is 0 outside WRITE.

## Timing
- Reset values: `cmd_ready=1`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`, `spr=0x7F`, `dar=0x00`, `empty=1`, `full=0`, `result=0x00`, `result_valid=0`, `err=0`, state IDLE.
- Latency: the accept edge ends cycle 0; `result_valid` is high in cycle k, and `cmd_ready` is high again in cycle k+1.
  - CLEAR and any rejected operation: k=1.
  - PUSH: k=2.
  - POP, TOP, DAR_INC, DAR_DEC: k=3.
  - ADD/SUB: k=5.
- `cmd_valid` while busy is ignored and is not queued; the requester holds it until `cmd_ready`.
- Reset asserted mid-operation: all registers return to reset values immediately and `mem_we` drops combinationally with the state. A write that has not reached its edge is lost.
- `spr` and `dar` update on the edge that leaves WRITE, or the edge that leaves IDLE for POP/TOP/INC/DEC/CLEAR. `empty`/`full` are combinational from `spr`.

## Structure
- Package `stack_pkg`:
  - `cmd_op` encodings as localparams.
  - FSM state enum.
  - `STACK_BASE = 7'h7F`.
  - `STACK_MIN2 = 7'h7D`.
- Single module with inline add/subtract; no sub-module. The `memory` instance stays in the top level.

## Test plan
- Reset → `spr=0x7F`, `empty=1`, `cmd_ready=1`. Then POP → `err` pulse at k=1 and `spr` stays 0x7F.
- PUSH 0x05, then PUSH 0x03 → writes at 0x7F and 0x7E, `spr=0x7D`, `result=0x03`, `result_valid` at k=2 each time.
- With 0x05 and 0x03 on the stack, SUB → 0x02 written at 0x7F, `spr=0x7E`, `dar=0x7F`, `result=0x02` at k=5. ADD instead → `result=0x08`.
- PUSH 0xF0 and 0x20, then ADD → `result=0x10` (wraps). PUSH 0x01 and 0x02, then SUB → `result=0xFF`.
- Push 127 values → `full=1`; a 128th PUSH gives `err` and no write. CLEAR → `spr=0x7F`, `dar=0`, `result=0`.
- DAR_DEC from `dar=0x00` → `dar=0x7F`, `result=mem[0x7F]` at k=3. Assert `rst_n` low during the WRITE of an ADD → no write, all outputs at reset values.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared encodings for the stack-calculator sequencer: opcodes, FSM states and
// stack pointer landmarks.
`timescale 1ns/1ps
package stack_pkg;

   localparam logic [2:0] OP_PUSH    = 3'd0;
   localparam logic [2:0] OP_POP     = 3'd1;
   localparam logic [2:0] OP_ADD     = 3'd2;
   localparam logic [2:0] OP_SUB     = 3'd3;
   localparam logic [2:0] OP_TOP     = 3'd4;
   localparam logic [2:0] OP_CLEAR   = 3'd5;
   localparam logic [2:0] OP_DAR_DEC = 3'd6;
   localparam logic [2:0] OP_DAR_INC = 3'd7;

   localparam logic [6:0] STACK_BASE = 7'h7F;
   localparam logic [6:0] STACK_MIN2 = 7'h7D;

   typedef enum logic [2:0] {
      StIdle,
      StRdA,
      StRdB,
      StCapB,
      StWrite,
      StFetch,
      StCapF,
      StDone
   } state_e;

endpackage

// File: rtl/stack_op_sequencer.sv
// Sequencer for the 128x8 stack memory: accepts one operation at a time, owns the stack
// pointer and display address, and does the 8-bit add/subtract inline.
`timescale 1ns/1ps
module stack_op_sequencer
   import stack_pkg::*;
#(
   parameter int unsigned AW = 7,
   parameter int unsigned DW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cmd_valid,
   input  logic [2:0]    cmd_op,
   input  logic [DW-1:0] cmd_din,
   output logic          cmd_ready,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic [AW-1:0] spr,
   output logic [AW-1:0] dar,
   output logic          empty,
   output logic          full,
   output logic [DW-1:0] result,
   output logic          result_valid,
   output logic          err
);

   localparam logic [AW-1:0] Base = AW'(STACK_BASE);
   localparam logic [AW-1:0] Min2 = AW'(STACK_MIN2);
   localparam logic [AW-1:0] One  = AW'(1);
   localparam logic [AW-1:0] Two  = AW'(2);

   state_e        state_q;
   logic [2:0]    op_q;
   logic [DW-1:0] din_q, a_q, b_q, result_q;
   logic [AW-1:0] spr_q, dar_q;
   logic          rv_q, err_q;
   logic [DW-1:0] alu;

   assign empty        = (spr_q == Base);
   assign full         = (spr_q == '0);
   assign cmd_ready    = (state_q == StIdle);
   assign spr          = spr_q;
   assign dar          = dar_q;
   assign result       = result_q;
   assign result_valid = rv_q;
   assign err          = err_q;

   // B is the deeper entry, so SUB computes B - A.
   assign alu = (op_q == OP_SUB) ? (b_q - a_q) : (b_q + a_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         op_q     <= OP_PUSH;
         din_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         spr_q    <= Base;
         dar_q    <= '0;
         result_q <= '0;
         rv_q     <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         rv_q  <= 1'b0;
         err_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (cmd_valid) begin
                  op_q  <= cmd_op;
                  din_q <= cmd_din;
                  case (cmd_op)
                     OP_PUSH: begin
                        if (full) begin
                           state_q <= StDone;
                           rv_q    <= 1'b1;
                           err_q   <= 1'b1;
                        end else begin
                           state_q <= StWrite;
                        end
                     end
                     OP_POP: begin
                        if (empty) begin
                           state_q <= StDone;
                           rv_q    <= 1'b1;
                           err_q   <= 1'b1;
                        end else begin
                           spr_q   <= spr_q + One;
                           dar_q   <= spr_q + Two;
                           state_q <= StFetch;
                        end
                     end
                     OP_ADD, OP_SUB: begin
                        if (spr_q > Min2) begin
                           state_q <= StDone;
                           rv_q    <= 1'b1;
                           err_q   <= 1'b1;
                        end else begin
                           state_q <= StRdA;
                        end
                     end
                     OP_TOP: begin
                        dar_q   <= spr_q + One;
                        state_q <= StFetch;
                     end
                     OP_CLEAR: begin
                        spr_q    <= Base;
                        dar_q    <= '0;
                        result_q <= '0;
                        state_q  <= StDone;
                        rv_q     <= 1'b1;
                     end
                     OP_DAR_DEC: begin
                        dar_q   <= dar_q - One;
                        state_q <= StFetch;
                     end
                     default: begin
                        dar_q   <= dar_q + One;
                        state_q <= StFetch;
                     end
                  endcase
               end
            end
            StRdA: state_q <= StRdB;
            StRdB: begin
               a_q     <= mem_rdata;
               state_q <= StCapB;
            end
            StCapB: begin
               b_q     <= mem_rdata;
               state_q <= StWrite;
            end
            StWrite: begin
               if (op_q == OP_PUSH) begin
                  spr_q    <= spr_q - One;
                  dar_q    <= spr_q;
                  result_q <= din_q;
               end else begin
                  spr_q    <= spr_q + One;
                  dar_q    <= spr_q + Two;
                  result_q <= alu;
               end
               state_q <= StDone;
               rv_q    <= 1'b1;
            end
            StFetch: state_q <= StCapF;
            StCapF: begin
               // Popping the last entry leaves nothing to display.
               if (op_q == OP_POP && empty) result_q <= '0;
               else                         result_q <= mem_rdata;
               state_q <= StDone;
               rv_q    <= 1'b1;
            end
            StDone: state_q <= StIdle;
         endcase
      end
   end

   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = dar_q;
      mem_wdata = '0;
      case (state_q)
         StRdA: mem_addr = spr_q + One;
         StRdB: mem_addr = spr_q + Two;
         StWrite: begin
            mem_we = 1'b1;
            if (op_q == OP_PUSH) begin
               mem_addr  = spr_q;
               mem_wdata = din_q;
            end else begin
               mem_addr  = spr_q + Two;
               mem_wdata = alu;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_stack_op_sequencer.sv
// Directed bench for stack_op_sequencer with a synchronous-read memory model behind it.
`timescale 1ns/1ps
module tb_stack_op_sequencer;
   import stack_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic [2:0] cmd_op = 3'd0;
   logic [7:0] cmd_din = 8'd0;
   logic       cmd_ready, mem_we, empty, full, result_valid, err;
   logic [6:0] mem_addr, spr, dar;
   logic [7:0] mem_wdata, mem_rdata, result;

   logic [7:0] mem [128];
   int         wr_cnt = 0;
   int         last_waddr = -1;
   int         last_wdata = -1;
   int         n_tests = 0;
   int         n_fail = 0;

   stack_op_sequencer #(.AW(7), .DW(8)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_din(cmd_din),
      .cmd_ready(cmd_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .spr(spr), .dar(dar), .empty(empty), .full(full),
      .result(result), .result_valid(result_valid), .err(err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_we) begin
         mem[mem_addr] <= mem_wdata;
         wr_cnt        <= wr_cnt + 1;
         last_waddr    <= int'(mem_addr);
         last_wdata    <= int'(mem_wdata);
      end
      mem_rdata <= mem[mem_addr];
   end

   task automatic check(input string tag, input int obs, input int exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, " ready"}, int'(cmd_ready), 1);
      check({tag, " we"}, int'(mem_we), 0);
      check({tag, " addr"}, int'(mem_addr), 0);
      check({tag, " wdata"}, int'(mem_wdata), 0);
      check({tag, " spr"}, int'(spr), 'h7F);
      check({tag, " dar"}, int'(dar), 0);
      check({tag, " empty"}, int'(empty), 1);
      check({tag, " full"}, int'(full), 0);
      check({tag, " result"}, int'(result), 0);
      check({tag, " rv"}, int'(result_valid), 0);
      check({tag, " err"}, int'(err), 0);
   endtask

   task automatic wait_ready(input string tag);
      bit ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (cmd_ready) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) check({tag, " ready timeout"}, 0, 1);
   endtask

   // Issues one operation from a negedge and checks latency, err and ready recovery.
   task automatic do_op(input logic [2:0] op, input logic [7:0] din, input int exp_k,
                        input int exp_err, input string tag);
      int k = 0;
      int e = 0;
      wait_ready(tag);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_din   = din;
      @(posedge clk);
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (c == 1) cmd_valid = 1'b0;
         if (result_valid) begin
            k = c;
            e = int'(err);
            break;
         end
      end
      check({tag, " k"}, k, exp_k);
      check({tag, " err"}, e, exp_err);
      @(negedge clk);
      check({tag, " ready"}, int'(cmd_ready), 1);
      check({tag, " rv pulse"}, int'(result_valid), 0);
   endtask

   initial begin
      int w;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      check_reset("reset");

      do_op(OP_POP, 8'h00, 1, 1, "pop_empty");
      check("pop_empty spr", int'(spr), 'h7F);

      do_op(OP_PUSH, 8'h05, 2, 0, "push05");
      check("push05 waddr", last_waddr, 'h7F);
      check("push05 spr", int'(spr), 'h7E);
      check("push05 dar", int'(dar), 'h7F);
      do_op(OP_PUSH, 8'h03, 2, 0, "push03");
      check("push03 waddr", last_waddr, 'h7E);
      check("push03 spr", int'(spr), 'h7D);
      check("push03 result", int'(result), 'h03);

      do_op(OP_SUB, 8'h00, 5, 0, "sub");
      check("sub waddr", last_waddr, 'h7F);
      check("sub wdata", last_wdata, 'h02);
      check("sub spr", int'(spr), 'h7E);
      check("sub dar", int'(dar), 'h7F);
      check("sub result", int'(result), 'h02);

      do_op(OP_POP, 8'h00, 3, 0, "pop_last");
      check("pop_last spr", int'(spr), 'h7F);
      check("pop_last dar", int'(dar), 0);
      check("pop_last result", int'(result), 0);

      do_op(OP_PUSH, 8'h05, 2, 0, "push05b");
      do_op(OP_PUSH, 8'h03, 2, 0, "push03b");
      do_op(OP_ADD, 8'h00, 5, 0, "add");
      check("add result", int'(result), 'h08);
      check("add spr", int'(spr), 'h7E);
      do_op(OP_POP, 8'h00, 3, 0, "pop_add");

      do_op(OP_PUSH, 8'hF0, 2, 0, "pushF0");
      do_op(OP_PUSH, 8'h20, 2, 0, "push20");
      do_op(OP_ADD, 8'h00, 5, 0, "add_wrap");
      check("add_wrap result", int'(result), 'h10);
      do_op(OP_POP, 8'h00, 3, 0, "pop_wrap");

      do_op(OP_PUSH, 8'h01, 2, 0, "push01");
      do_op(OP_PUSH, 8'h02, 2, 0, "push02");
      do_op(OP_SUB, 8'h00, 5, 0, "sub_wrap");
      check("sub_wrap result", int'(result), 'hFF);

      do_op(OP_TOP, 8'h00, 3, 0, "top");
      check("top dar", int'(dar), 'h7F);
      check("top result", int'(result), 'hFF);

      do_op(OP_CLEAR, 8'h00, 1, 0, "clear1");
      check("clear1 spr", int'(spr), 'h7F);
      check("clear1 result", int'(result), 0);

      // Entry at address a holds 0x80 - a.
      for (int i = 0; i < 127; i++) do_op(OP_PUSH, 8'(i + 1), 2, 0, "fill");
      check("fill full", int'(full), 1);
      check("fill spr", int'(spr), 0);
      w = wr_cnt;
      do_op(OP_PUSH, 8'hAA, 1, 1, "push_full");
      check("push_full nowrite", wr_cnt, w);
      check("push_full spr", int'(spr), 0);

      do_op(OP_ADD, 8'h00, 5, 0, "add_full");
      check("add_full result", int'(result), 'hFD);
      check("add_full spr", int'(spr), 'h01);
      check("add_full dar", int'(dar), 'h02);

      do_op(OP_CLEAR, 8'h00, 1, 0, "clear2");
      check("clear2 spr", int'(spr), 'h7F);
      check("clear2 dar", int'(dar), 0);
      check("clear2 result", int'(result), 0);

      do_op(OP_DAR_DEC, 8'h00, 3, 0, "dec1");
      check("dec1 dar", int'(dar), 'h7F);
      check("dec1 result", int'(result), 'h01);
      do_op(OP_DAR_DEC, 8'h00, 3, 0, "dec2");
      check("dec2 dar", int'(dar), 'h7E);
      check("dec2 result", int'(result), 'h02);
      do_op(OP_DAR_INC, 8'h00, 3, 0, "inc");
      check("inc dar", int'(dar), 'h7F);
      check("inc result", int'(result), 'h01);

      do_op(OP_PUSH, 8'h09, 2, 0, "push09");
      do_op(OP_ADD, 8'h00, 1, 1, "add_short");
      check("add_short spr", int'(spr), 'h7E);
      check("add_short result", int'(result), 'h09);
      do_op(OP_PUSH, 8'h04, 2, 0, "push04");

      // Reset lands in the WRITE cycle of an ADD (cycle 4 after accept).
      w = wr_cnt;
      wait_ready("rst_mid");
      cmd_valid = 1'b1;
      cmd_op    = OP_ADD;
      cmd_din   = 8'h00;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_mid we", int'(mem_we), 1);
      check("rst_mid addr", int'(mem_addr), 'h7F);
      check("rst_mid wdata", int'(mem_wdata), 'h0D);
      rst_n = 1'b0;
      #1;
      check("rst_mid we drop", int'(mem_we), 0);
      @(posedge clk);
      @(negedge clk);
      check("rst_mid nowrite", wr_cnt, w);
      check("rst_mid mem", int'(mem[7'h7F]), 'h09);
      check_reset("rst_mid");
      rst_n = 1'b1;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
